// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers returned words
// with their PCs, and flushes/refetches on a branch or jump redirect.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [31:0]               memAdr,
    input  logic [31:0]               memInst,
    input  logic                      memReady,
    output logic [31:0]               instOut,
    output logic [31:0]               pcOut,
    output logic                      instValid,
    input  logic                      deqReady,
    input  logic                      redirect,
    input  logic [31:0]               redirectPc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fpc;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] occ;
    logic          deq;
    logic          enq;

    assign instValid = (occ != '0);
    assign deq       = instValid & deqReady;
    // A full queue still accepts a fetch when the head leaves this cycle.
    assign enq       = memReady & ~redirect & ((occ < FULL) | deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (redirect) begin
            fpc    <= {redirectPc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
                fpc    <= fpc + 32'd4;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[wr_ptr] <= memInst;
            pc_mem[wr_ptr]   <= fpc;
        end
    end

    assign memAdr  = fpc;
    assign count   = occ;
    assign instOut = instValid ? inst_mem[rd_ptr] : 32'h0;
    assign pcOut   = instValid ? pc_mem[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_inst_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] memAdr;
    logic [31:0] memInst;
    logic        memReady;
    logic [31:0] instOut;
    logic [31:0] pcOut;
    logic        instValid;
    logic        deqReady;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [2:0]  count;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .memAdr(memAdr), .memInst(memInst), .memReady(memReady),
        .instOut(instOut), .pcOut(pcOut), .instValid(instValid),
        .deqReady(deqReady), .redirect(redirect),
        .redirectPc(redirectPc), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of (pc, inst) plus fetch PC.
    logic [31:0] m_fpc;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    bit          rand_inst;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("memAdr", memAdr, m_fpc);
        check("count", 32'(count), 32'(q_pc.size()));
        check("instValid", 32'(instValid), 32'(q_pc.size() != 0));
        check("pcOut", pcOut,
              (q_pc.size() != 0) ? q_pc[0] : 32'h0);
        check("instOut", instOut,
              (q_inst.size() != 0) ? q_inst[0] : 32'h0);
    endtask

    // One clock: drive inputs, step model at the edge, compare at negedge.
    task automatic cyc(input bit mr, input bit dr,
                       input bit rd, input logic [31:0] rpc);
        bit do_deq;
        bit do_enq;
        memReady   = mr;
        deqReady   = dr;
        redirect   = rd;
        redirectPc = rpc;
        memInst    = rand_inst ? $urandom : 32'h1000_0000 + m_fpc;
        @(posedge clk);
        do_deq = (q_pc.size() != 0) && dr;
        if (rd) begin
            q_pc.delete();
            q_inst.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            do_enq = mr && ((q_pc.size() < DEPTH) || do_deq);
            if (do_deq) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (do_enq) begin
                q_pc.push_back(m_fpc);
                q_inst.push_back(memInst);
                m_fpc = m_fpc + 32'd4;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_inst.delete();
        m_fpc = RPC;
    endtask

    initial begin
        rand_inst  = 1'b0;
        rst_n      = 1'b0;
        memReady   = 1'b0;
        deqReady   = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        memInst    = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Stream: one per cycle, count stays 1.
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);
        check("stream_count", 32'(count), 32'd1);

        // Fill and backpressure from a fresh start at 0.
        cyc(0, 0, 1, 32'h0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        check("full_adr", memAdr, 32'd16);
        check("full_count", 32'(count), 32'd4);

        // Full with simultaneous enq/deq.
        cyc(1, 1, 0, 0);
        check("fulldeq_adr", memAdr, 32'd20);
        check("fulldeq_pc", pcOut, 32'd4);
        check("fulldeq_count", 32'(count), 32'd4);

        // Drain in order.
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);

        // Redirect with count 3.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        check("pre_redir_count", 32'(count), 32'd3);
        cyc(1, 1, 1, 32'h0000_0102);
        check("redir_adr", memAdr, 32'h0000_0100);
        check("redir_valid", 32'(instValid), 32'd0);
        cyc(1, 0, 0, 0);
        check("redir_pc", pcOut, 32'h0000_0100);

        // Memory wait mid-stream.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

        // Async reset between edges with count 2.
        cyc(1, 0, 0, 0);
        check("pre_rst_count", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_adr", memAdr, RPC);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);

        // Random traffic.
        rand_inst = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0,
                ($urandom % 5) < 3,
                ($urandom % 20) == 0,
                $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
# inst_prefetch_queue

Instruction prefetch queue between the instruction memory and the pipeline's IF/ID boundary. Owns the fetch PC, drives the instruction-memory address, and captures returned words with their PCs into a DEPTH-entry FIFO. Presents the FIFO head to the pipeline with a valid/ready handshake. On a branch or jump redirect it flushes all queued entries and restarts fetch at the new target.

## Interface
- DEPTH, 4: queue entries; power of 2, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- memAdr  out  32  instruction-memory address; equals the fetch PC register.
- memInst  in  32  instruction word at memAdr; combinational, same-cycle.
- memReady  in  1  memInst is valid this cycle; low means memory wait.
- instOut  out  32  instruction at the queue head.
- pcOut  out  32  PC of the queue head.
- instValid  out  1  queue non-empty; instOut/pcOut meaningful.
- deqReady  in  1  pipeline accepts the head this cycle.
- redirect  in  1  flush and refetch request (branch/jump resolved).
- redirectPc  in  32  new fetch target; bits [1:0] forced to 0.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- State:
  - fetch PC register fpc.
  - storage arrays instMem_q[DEPTH] and pcMem_q[DEPTH].
  - head pointer rdPtr and tail pointer wrPtr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - occupancy register count.
- deq = instValid & deqReady.
- enq = memReady & ~redirect & (count < DEPTH | deq).
  - A full queue with a same-cycle dequeue still accepts a fetch.
- On enq at clock edge:
  - instMem_q[wrPtr] <= memInst; pcMem_q[wrPtr] <= fpc.
  - wrPtr increments; fpc <= fpc + 4, wrapping modulo 2^32.
- On deq: rdPtr increments.
- Occupancy update: count +1 on enq only, -1 on deq only, unchanged on both or neither.
- Redirect has priority over everything:
  - rdPtr, wrPtr and count clear to 0; fpc <= {redirectPc[31:2], 2'b00}.
  - The memInst returned that cycle is discarded; no enqueue.
  - A deq presented in the redirect cycle is still considered taken by the pipeline (the head is consumed), then the queue is flushed.
- Outputs:
  - instValid = (count != 0).
  - instOut = instMem_q[rdPtr] and pcOut = pcMem_q[rdPtr] when valid; both are forced to 0 when empty.
- memAdr = fpc. It holds while memReady is low or the queue is full without a dequeue.

## Timing
- Reset (rst_n low, asynchronous): fpc=RESET_PC, rdPtr=wrPtr=0, count=0, instValid=0, instOut=0, pcOut=0, memAdr=RESET_PC. Storage contents are don't-care.
- Reset asserted mid-operation clears state immediately, with no clock needed. The first fetch happens on the first rising edge after rst_n rises.
- Fetch-to-present latency: a word accepted at edge N is visible on instOut/instValid right after edge N, during cycle N+1.
- Sustained throughput: 1 instruction/cycle with memReady=1 and deqReady=1, with count steady at 1.
- Redirect latency: redirect at edge N puts memAdr=redirectPc after edge N. The first target instruction is valid after edge N+1.
- Full (count==DEPTH), no deq: memAdr frozen, no overwrite.
- Empty: deqReady is ignored and count never underflows.
- Pointer wrap from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset then stream: RESET_PC=0, memInst=32'h1000_0000+adr, memReady=1, deqReady=1 → pcOut 0,4,8,… on consecutive cycles; instValid high from the second cycle on; count stays 1.
- Fill and backpressure: deqReady=0 for 10 cycles → count reaches 4 after 4 edges and memAdr holds at 16. Raise deqReady → heads pop with PCs 0,4,8,12,16 in order, with no loss or duplicate.
- Full plus simultaneous enq/deq: with count=4, assert deqReady for one cycle → count stays 4, memAdr advances 16→20, head PC 0→4. The pointer wrap is exercised.
- Redirect flush: with count=3, assert redirect with redirectPc=32'h0000_0102 → next cycle count=0, instValid=0, memAdr=32'h0000_0100. One cycle later pcOut=32'h100.
- Memory wait: memReady low for 3 cycles mid-stream → memAdr holds and count drains by the dequeues. Fetch resumes from the held PC with no skipped address.
- Async reset mid-stream: drop rst_n between edges with count=2 → instValid, count, instOut and pcOut read 0 and memAdr reads RESET_PC before the next edge.
